uart_rx_frame: RTL and testbench

UART receiver that sits directly upstream of the system controller. It deserialises the rx_in line into bytes and delivers each one as p_data with a one-cycle data_vld strobe; these drive the controller's rx_p_data/rx_d_vld. It runs on the oversampled UART clock (prescale × baud) and checks parity and the stop bit. Only error-free frames are delivered.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sampler.sv | 80 ++++++++
 rtl/uart_rx_frame.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The RX_ERR_STICKY_EN build option is handled in uart_rx_frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // data_xor is the XOR reduction of the data bits.
  function automatic logic expected_parity(input logic par_typ, input logic data_xor);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit edge counter and 3-point majority sampler.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  input  logic                   cnt_en,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic                   rx_s,
  output logic                   sampled_bit,
  output logic                   sample_done,
  output logic                   bit_end
);

  localparam logic [PRESC_WIDTH-1:0] ONE = PRESC_WIDTH'(1);

  logic                   rx_meta_reg;
  logic                   rx_s_reg;
  logic [PRESC_WIDTH-1:0] edge_cnt_reg;
  logic [PRESC_WIDTH-1:0] edge_cnt_next;
  logic                   samp_a_reg;
  logic                   samp_b_reg;
  logic                   sampled_bit_reg;
  logic [PRESC_WIDTH-1:0] half;
  logic [PRESC_WIDTH-1:0] last_edge;
  logic                   take_a;
  logic                   take_b;

  assign half        = presc >> 1;
  assign last_edge   = presc - ONE;
  assign take_a      = cnt_en && (edge_cnt_reg == half - ONE);
  assign take_b      = cnt_en && (edge_cnt_reg == half);
  assign sample_done = cnt_en && (edge_cnt_reg == half + ONE);
  assign bit_end     = cnt_en && (edge_cnt_reg == last_edge);

  assign rx_s        = rx_s_reg;
  assign sampled_bit = sampled_bit_reg;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx_in;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_comb begin
    edge_cnt_next = edge_cnt_reg + ONE;
    if (!cnt_en || bit_end) begin
      edge_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_reg    <= '0;
      samp_a_reg      <= 1'b1;
      samp_b_reg      <= 1'b1;
      sampled_bit_reg <= 1'b1;
    end else begin
      edge_cnt_reg <= edge_cnt_next;
      if (take_a) begin
        samp_a_reg <= rx_s_reg;
      end
      if (take_b) begin
        samp_b_reg <= rx_s_reg;
      end
      if (sample_done) begin
        sampled_bit_reg <= majority3(samp_a_reg, samp_b_reg, rx_s_reg);
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start/data/parity/stop FSM, LSB-first shifter and error checks.
// Define RX_ERR_STICKY_EN to make par_err/stp_err sticky until err_clr.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic                   par_en,
  input  logic                   par_typ,
  input  logic                   err_clr,
  output logic [DATA_WIDTH-1:0]  p_data,
  output logic                   data_vld,
  output logic                   par_err,
  output logic                   stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  rx_state_t state_reg;
  rx_state_t state_next;

  logic                   rx_s;
  logic                   sampled_bit;
  logic                   sample_done;
  logic                   bit_end;
  logic                   cnt_en;

  logic [PRESC_WIDTH-1:0] presc_sel;
  logic [PRESC_WIDTH-1:0] presc_reg;
  logic                   par_en_reg;
  logic                   par_typ_reg;
  logic [BCW-1:0]         bit_cnt_reg;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [DATA_WIDTH-1:0]  shift_next;
  logic                   have_sample_reg;
  logic                   par_flag_reg;
  logic [DATA_WIDTH-1:0]  p_data_reg;
  logic                   data_vld_reg;
  logic                   par_err_reg;
  logic                   stp_err_reg;

  logic                   start_det;
  logic                   frame_end;
  logic                   stop_bad;
  logic                   frame_ok;

  assign cnt_en = (state_reg != IDLE);

  uart_rx_sampler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .cnt_en     (cnt_en),
    .presc      (presc_reg),
    .rx_s       (rx_s),
    .sampled_bit(sampled_bit),
    .sample_done(sample_done),
    .bit_end    (bit_end)
  );

  // Anything other than 16 or 32 falls back to 8x oversampling.
  always_comb begin
    presc_sel = PRESC_WIDTH'(PRESC_8);
    if (prescale == PRESC_WIDTH'(PRESC_16)) begin
      presc_sel = PRESC_WIDTH'(PRESC_16);
    end else if (prescale == PRESC_WIDTH'(PRESC_32)) begin
      presc_sel = PRESC_WIDTH'(PRESC_32);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start_det  = 1'b0;
    frame_end  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = (have_sample_reg && !sampled_bit) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt_reg == LAST_BIT)) begin
          state_next = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
      assign shift_next[gi] = shift_reg[gi+1];
    end
  endgenerate
  assign shift_next[DATA_WIDTH-1] = sampled_bit;

  assign stop_bad = !(have_sample_reg && sampled_bit);
  assign frame_ok = !stop_bad && !par_flag_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg       <= PRESC_WIDTH'(PRESC_8);
      par_en_reg      <= 1'b0;
      par_typ_reg     <= PAR_EVEN;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      have_sample_reg <= 1'b0;
      par_flag_reg    <= 1'b0;
      p_data_reg      <= '0;
      data_vld_reg    <= 1'b0;
    end else begin
      // Frame configuration is frozen at start detection.
      if (start_det) begin
        presc_reg    <= presc_sel;
        par_en_reg   <= par_en;
        par_typ_reg  <= par_typ;
        bit_cnt_reg  <= '0;
        par_flag_reg <= 1'b0;
      end

      if ((state_reg == IDLE) || bit_end) begin
        have_sample_reg <= 1'b0;
      end else if (sample_done) begin
        have_sample_reg <= 1'b1;
      end

      if ((state_reg == DATA) && bit_end) begin
        shift_reg   <= shift_next;
        bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + BCW'(1);
      end

      if ((state_reg == PARITY) && bit_end) begin
        par_flag_reg <= (sampled_bit != expected_parity(par_typ_reg, ^shift_reg));
      end

      data_vld_reg <= frame_end && frame_ok;
      if (frame_end && frame_ok) begin
        p_data_reg <= shift_reg;
      end
    end
  end

`ifdef RX_ERR_STICKY_EN
  // A new error at frame end takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err_reg <= 1'b0;
      stp_err_reg <= 1'b0;
    end else begin
      if (frame_end && par_flag_reg) begin
        par_err_reg <= 1'b1;
      end else if (err_clr) begin
        par_err_reg <= 1'b0;
      end
      if (frame_end && stop_bad) begin
        stp_err_reg <= 1'b1;
      end else if (err_clr) begin
        stp_err_reg <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err_reg <= 1'b0;
      stp_err_reg <= 1'b0;
    end else begin
      par_err_reg <= frame_end && par_flag_reg;
      stp_err_reg <= frame_end && stop_bad;
    end
  end
`endif

  assign p_data   = p_data_reg;
  assign data_vld = data_vld_reg;
  assign par_err  = par_err_reg;
  assign stp_err  = stp_err_reg;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Table-driven bench for uart_rx_frame with an expected-event scoreboard.
module tb_uart_rx_frame;

`ifdef RX_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       err_clr;
  logic [7:0] p_data;
  logic       data_vld;
  logic       par_err;
  logic       stp_err;

  uart_rx_frame #(
    .DATA_WIDTH (8),
    .PRESC_WIDTH(6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx_in),
    .prescale(prescale),
    .par_en  (par_en),
    .par_typ (par_typ),
    .err_clr (err_clr),
    .p_data  (p_data),
    .data_vld(data_vld),
    .par_err (par_err),
    .stp_err (stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         bit_len;
    logic [5:0] presc;
    bit         pe;
    bit         pt;
    logic [7:0] data;
    bit         pbit;
    bit         stop;
    bit         exp_vld;
    bit         exp_par;
    bit         exp_stp;
  } vec_t;

  typedef struct {
    bit         vld;
    logic [7:0] data;
    bit         par;
    bit         stp;
  } exp_t;

  vec_t       vecs[9];
  exp_t       exp_q[$];
  int         vld_times[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         ev_count = 0;
  logic [7:0] last_good;
  bit         vld_q, par_q, stp_q;
  exp_t       e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  // One line per observed output transaction, compared against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      vld_q = 1'b0;
      par_q = 1'b0;
      stp_q = 1'b0;
    end else begin
      if (data_vld) check("vld_one_cycle", vld_q, 0);
      if (data_vld || (par_err && !par_q) || (stp_err && !stp_q)) begin
        ev_count++;
        if (data_vld) vld_times.push_back(cyc);
        $display("rx event @%0d: vld=%0b p_data=%02h par_err=%0b stp_err=%0b",
                 cyc, data_vld, p_data, par_err, stp_err);
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data_vld", data_vld, e.vld);
          check("p_data", p_data, e.data);
          check("par_err", par_err, e.par);
          check("stp_err", stp_err, e.stp);
        end
      end
      vld_q = data_vld;
      par_q = par_err;
      stp_q = stp_err;
    end
  end

  task automatic push(input bit vld, input logic [7:0] data, input bit par, input bit stp);
    if (vld) last_good = data;
    exp_q.push_back('{vld, last_good, par, stp});
  endtask

  task automatic send_frame(input int bit_len, input logic [7:0] data, input bit with_par,
                            input bit pbit, input bit stop);
    rx_in = 1'b0;
    repeat (bit_len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      repeat (bit_len) @(negedge clk);
    end
    if (with_par) begin
      rx_in = pbit;
      repeat (bit_len) @(negedge clk);
    end
    rx_in = stop;
    repeat (bit_len) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int gap;
    //           len presc pe pt data   pbit stop vld par stp
    vecs[0] = '{8,  6'd8,  1, 0, 8'hA5, 0,   1,   1,  0,  0};
    vecs[1] = '{8,  6'd8,  1, 1, 8'h3C, 0,   1,   0,  1,  0};
    vecs[2] = '{16, 6'd16, 0, 0, 8'h55, 0,   0,   0,  0,  1};
    vecs[3] = '{16, 6'd16, 0, 0, 8'h0F, 0,   1,   1,  0,  0};
    vecs[4] = '{8,  6'd8,  1, 1, 8'h3C, 1,   1,   1,  0,  0};
    vecs[5] = '{8,  6'd8,  1, 0, 8'h07, 0,   0,   0,  1,  1};
    vecs[6] = '{8,  6'd20, 0, 0, 8'h81, 0,   1,   1,  0,  0};
    vecs[7] = '{16, 6'd16, 1, 0, 8'hFF, 0,   1,   1,  0,  0};
    vecs[8] = '{32, 6'd32, 0, 0, 8'h00, 0,   1,   1,  0,  0};

    rst = 1'b0; rx_in = 1'b1; err_clr = 1'b0;
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_p_data", p_data, 0);
    check("reset_data_vld", data_vld, 0);
    check("reset_par_err", par_err, 0);
    check("reset_stp_err", stp_err, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      prescale = vecs[i].presc;
      par_en   = vecs[i].pe;
      par_typ  = vecs[i].pt;
      push(vecs[i].exp_vld, vecs[i].data, vecs[i].exp_par, vecs[i].exp_stp);
      send_frame(vecs[i].bit_len, vecs[i].data, vecs[i].pe, vecs[i].pbit, vecs[i].stop);
      drain();
      pulse_clr();
    end

    // Short low glitch must not produce any output.
    prescale = 6'd16; par_en = 1'b0;
    e0 = ev_count;
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_events", ev_count, e0);
    push(1, 8'h3A, 0, 0);
    send_frame(16, 8'h3A, 0, 0, 1);
    drain();

    // Configuration changes mid-frame are ignored.
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    push(1, 8'h5A, 0, 0);
    fork
      send_frame(8, 8'h5A, 1, 0, 1);
      begin
        repeat (30) @(negedge clk);
        prescale = 6'd16; par_en = 1'b0; par_typ = 1'b1;
      end
    join
    drain();

    // Back-to-back frames at 32x.
    prescale = 6'd32; par_en = 1'b0;
    vld_times.delete();
    push(1, 8'hAA, 0, 0);
    push(1, 8'hDD, 0, 0);
    send_frame(32, 8'hAA, 0, 0, 1);
    send_frame(32, 8'hDD, 0, 0, 1);
    drain();
    check("b2b_count", vld_times.size(), 2);
    gap = (vld_times.size() == 2) ? vld_times[1] - vld_times[0] : 0;
    check("b2b_gap_in_range", (gap >= 320 && gap <= 322), 1);

    // Reset in the middle of DATA of 0xCC aborts that frame.
    prescale = 6'd8; par_en = 1'b0;
    e0 = ev_count;
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    rx_in = 1'b0; repeat (8) @(negedge clk);
    rx_in = 1'b0; repeat (8) @(negedge clk);
    rx_in = 1'b1; repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    rst = 1'b1;
    check("midreset_p_data", p_data, 0);
    last_good = 8'h00;
    repeat (40) @(negedge clk);
    check("midreset_events", ev_count, e0);
    push(1, 8'h11, 0, 0);
    send_frame(8, 8'h11, 0, 0, 1);
    drain();

    // Error flag persistence: sticky holds until err_clr, pulse mode drops after one cycle.
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1;
    push(0, 8'h00, 1, 0);
    send_frame(8, 8'h3C, 1, 0, 1);
    drain();
    repeat (5) @(negedge clk);
    check("par_err_hold", par_err, STICKY);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("par_err_after_clr", par_err, 0);
    check("p_data_after_par_err", p_data, 8'h11);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
